// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory subsystem: FSM encoding, default widths
// and the command codes decoded by the RAM.
package spi_pkg;

    localparam int unsigned FRAME_W_DEF = 10;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned CNT_W       = 4;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StChkCmd   = 3'd1,
        StWrite    = 3'd2,
        StReadAdd  = 3'd3,
        StReadData = 3'd4,
        StDone     = 3'd5
    } state_e;

    // Phases inside StReadData: frame shift-in, wait for RAM byte, byte shift-out.
    typedef enum logic [1:0] {
        RdFrame = 2'd0,
        RdWait  = 2'd1,
        RdShift = 2'd2
    } rd_stage_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises command/data frames for the RAM and shifts
// read-back bytes out on miso for read-data commands.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    state_e             state_q, state_d;
    rd_stage_e          rd_stage_q, rd_stage_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0] frame_q, frame_d;
    logic [DATA_W-2:0]  tx_shift_q, tx_shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               miso_q, miso_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;
    logic               frame_last;
    logic               tx_last;

    always_comb begin
        state_d        = state_q;
        rd_stage_d     = rd_stage_q;
        bit_cnt_d      = bit_cnt_q;
        frame_d        = frame_q;
        tx_shift_d     = tx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        frame_last     = (bit_cnt_q == CNT_W'(FRAME_W - 2));
        tx_last        = (bit_cnt_q == CNT_W'(DATA_W - 2));

        if (ss_n) begin
            state_d    = StIdle;
            rd_stage_d = RdFrame;
            bit_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StChkCmd;
                    bit_cnt_d = '0;
                end
                StChkCmd: begin
                    frame_d    = {{(FRAME_W-2){1'b0}}, mosi};
                    bit_cnt_d  = '0;
                    rd_stage_d = RdFrame;
                    if (!mosi) begin
                        state_d = StWrite;
                    end else if (rd_addr_seen_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StReadAdd;
                    end
                end
                StWrite, StReadAdd: begin
                    frame_d   = {frame_q[FRAME_W-3:0], mosi};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (frame_last) begin
                        rx_data_d  = {frame_q, mosi};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = StDone;
                        if (state_q == StReadAdd) begin
                            rd_addr_seen_d = 1'b1;
                        end
                    end
                end
                StReadData: begin
                    unique case (rd_stage_q)
                        RdFrame: begin
                            frame_d   = {frame_q[FRAME_W-3:0], mosi};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (frame_last) begin
                                rx_data_d  = {frame_q, mosi};
                                rx_valid_d = 1'b1;
                                bit_cnt_d  = '0;
                                rd_stage_d = RdWait;
                            end
                        end
                        RdWait: begin
                            // RAM answers the edge after rx_valid; a level seen
                            // while rx_valid is still high is stale.
                            if (tx_valid && !rx_valid_q) begin
                                miso_d     = tx_data[DATA_W-1];
                                tx_shift_d = tx_data[DATA_W-2:0];
                                bit_cnt_d  = '0;
                                rd_stage_d = RdShift;
                            end
                        end
                        RdShift: begin
                            miso_d     = tx_shift_q[DATA_W-2];
                            tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 1'b1;
                            if (tx_last) begin
                                bit_cnt_d      = '0;
                                rd_addr_seen_d = 1'b0;
                                rd_stage_d     = RdFrame;
                                state_d        = StDone;
                            end
                        end
                        default: rd_stage_d = RdFrame;
                    endcase
                end
                StDone: begin
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            rd_stage_q     <= RdFrame;
            bit_cnt_q      <= '0;
            frame_q        <= '0;
            tx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_stage_q     <= rd_stage_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            tx_shift_q     <= tx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: edge-indexed transactions against a
// transaction-level model of frame capture and read-back timing.
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    spi_slave #(
        .FRAME_W(10),
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        int         n;
        int         tx_at;
        logic [7:0] tx_byte;
        logic [7:0] stale_byte;
        bit         stale_valid;
        int         rst_at;
    } txn_t;

    int errors = 0;
    int checks = 0;
    bit m_seen = 1'b0;

    // Observations from the last transaction; bit k of o_miso is miso after edge Ek.
    logic [21:0] o_rx;
    logic [39:0] o_miso;
    logic [1:0]  o_tail;
    logic [9:0]  o_rst_rxd;
    logic [21:0] e_rx;
    logic [39:0] e_miso;

    function automatic txn_t mk(logic [9:0] frame, int n, int tx_at, logic [7:0] tx_byte,
                                logic [7:0] stale_byte, bit stale_valid, int rst_at);
        txn_t t;
        t.frame = frame; t.n = n; t.tx_at = tx_at; t.tx_byte = tx_byte;
        t.stale_byte = stale_byte; t.stale_valid = stale_valid; t.rst_at = rst_at;
        return t;
    endfunction

    task automatic run_frame(input txn_t t);
        int cnt = 0;
        int edg = 0;
        logic [9:0] rxd = '0;
        o_miso = '0;
        o_rst_rxd = '0;
        tx_valid = t.stale_valid;
        tx_data = t.stale_byte;
        ss_n = 1'b0;
        mosi = 1'($urandom);
        for (int k = 0; k < t.n; k++) begin
            @(posedge clk); #1;
            if (rx_valid) begin
                cnt++;
                edg = k;
                rxd = rx_data;
            end
            o_miso[k] = miso;
            if (k == t.rst_at) begin
                o_rst_rxd = rx_data;
                rst = 1'b0;
                break;
            end
            if (k + 1 == t.rst_at) rst = 1'b1;
            mosi = (k <= 9) ? t.frame[9-k] : 1'($urandom);
            if (k == t.tx_at) begin
                tx_valid = 1'b1;
                tx_data = t.tx_byte;
            end
        end
        ss_n = 1'b1;
        @(posedge clk); #1;
        o_tail = {rx_valid, miso};
        tx_valid = 1'b0;
        o_rx = {4'(cnt), 8'(edg), rxd};
    endtask

    // Frame seen iff E10 is reached; read-back runs for read-data frames from the
    // first edge >= E12 where the RAM level is high, 8 bits MSB first.
    task automatic model_frame(input txn_t t);
        int  n_eff = (t.rst_at < t.n) ? t.rst_at : t.n;
        bit  is_rd = t.frame[9] && m_seen;
        int  acc = -1;
        logic [7:0] b;
        e_rx = '0;
        e_miso = '0;
        if (n_eff > 10) begin
            e_rx = {4'd1, 8'd10, t.frame};
            if (t.frame[9] && !m_seen) m_seen = 1'b1;
        end
        if (is_rd && n_eff > 10) begin
            for (int k = 12; k < n_eff; k++) begin
                if (t.stale_valid || (t.tx_at >= 0 && t.tx_at < k)) begin
                    acc = k;
                    break;
                end
            end
            if (acc >= 0) begin
                b = (t.tx_at >= 0 && t.tx_at < acc) ? t.tx_byte : t.stale_byte;
                for (int i = 0; i < 8; i++)
                    if (acc + i < n_eff) e_miso[acc+i] = b[7-i];
                if (acc + 7 < n_eff) m_seen = 1'b0;
            end
        end
        if (t.rst_at < t.n) m_seen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ss_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (miso !== 1'b0) begin
            errors++; $display("FAIL reset miso: got %b want 0", miso);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset rx_valid: got %b want 0", rx_valid);
        end
        checks++;
        if (rx_data !== 10'h000) begin
            errors++; $display("FAIL reset rx_data: got %h want 000", rx_data);
        end
        rst = 1'b0;
        m_seen = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        txn_t tv [3];
        tv[0] = mk(10'b00_0001_0000, 14, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[1] = mk(10'b01_1010_0101, 14, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[2] = mk(10'b01_0110_1001, 18, 11, 8'hFF, 8'h00, 1'b0, 1000);
        foreach (tv[i]) begin
            run_frame(tv[i]);
            model_frame(tv[i]);
            checks++;
            if (o_rx !== e_rx) begin
                errors++; $display("FAIL write[%0d] rx: got %h want %h", i, o_rx, e_rx);
            end
            checks++;
            if (o_miso !== e_miso) begin
                errors++; $display("FAIL write[%0d] miso: got %h want %h", i, o_miso, e_miso);
            end
            checks++;
            if (o_tail !== 2'b00) begin
                errors++; $display("FAIL write[%0d] tail: got %b want 00", i, o_tail);
            end
        end
    endtask

    task automatic test_read();
        txn_t tv [8];
        tv[0] = mk(10'b10_0001_0000, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[1] = mk(10'b11_0110_0011, 22, 11, 8'hA5, 8'h00, 1'b0, 1000);
        tv[2] = mk(10'b11_0000_0001, 22, 11, 8'hFF, 8'h00, 1'b0, 1000); // re-enters READ_ADD
        tv[3] = mk(10'b11_1111_0000, 22, 11, 8'hC3, 8'h3C, 1'b1, 1000); // sticky level
        tv[4] = mk(10'b10_0101_0101, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[5] = mk(10'b11_0101_0101, 26, 15, 8'h96, 8'h00, 1'b0, 1000); // late RAM byte
        tv[6] = mk(10'b10_0000_0011, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[7] = mk(10'b11_1000_0001, 22, 11, 8'h5A, 8'h00, 1'b0, 1000);
        foreach (tv[i]) begin
            run_frame(tv[i]);
            model_frame(tv[i]);
            checks++;
            if (o_rx !== e_rx) begin
                errors++; $display("FAIL read[%0d] rx: got %h want %h", i, o_rx, e_rx);
            end
            checks++;
            if (o_miso !== e_miso) begin
                errors++; $display("FAIL read[%0d] miso: got %h want %h", i, o_miso, e_miso);
            end
            checks++;
            if (o_tail !== 2'b00) begin
                errors++; $display("FAIL read[%0d] tail: got %b want 00", i, o_tail);
            end
        end
    endtask

    task automatic test_abort();
        txn_t tv [6];
        tv[0] = mk(10'b10_1100_1100, 6, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[1] = mk(10'b01_0011_0011, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[2] = mk(10'b10_0000_1111, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[3] = mk(10'b11_0000_1111, 16, 11, 8'hE7, 8'h00, 1'b0, 1000); // cut mid-shift
        tv[4] = mk(10'b11_1111_1111, 22, 11, 8'h81, 8'h00, 1'b0, 1000); // still READ_DATA
        tv[5] = mk(10'b00_1111_0000, 4, -1, 8'h00, 8'h00, 1'b0, 1000);
        foreach (tv[i]) begin
            run_frame(tv[i]);
            model_frame(tv[i]);
            checks++;
            if (o_rx !== e_rx) begin
                errors++; $display("FAIL abort[%0d] rx: got %h want %h", i, o_rx, e_rx);
            end
            checks++;
            if (o_miso !== e_miso) begin
                errors++; $display("FAIL abort[%0d] miso: got %h want %h", i, o_miso, e_miso);
            end
            checks++;
            if (o_tail !== 2'b00) begin
                errors++; $display("FAIL abort[%0d] tail: got %b want 00", i, o_tail);
            end
        end
    endtask

    task automatic test_reset_readback();
        txn_t tv [3];
        tv[0] = mk(10'b10_0010_0010, 12, -1, 8'h00, 8'h00, 1'b0, 1000);
        tv[1] = mk(10'b11_0010_0010, 22, 11, 8'hA5, 8'h00, 1'b0, 15);
        tv[2] = mk(10'b11_0100_0100, 22, 11, 8'hFF, 8'h00, 1'b0, 1000);
        foreach (tv[i]) begin
            run_frame(tv[i]);
            model_frame(tv[i]);
            checks++;
            if (o_rx !== e_rx) begin
                errors++; $display("FAIL rstrb[%0d] rx: got %h want %h", i, o_rx, e_rx);
            end
            checks++;
            if (o_miso !== e_miso) begin
                errors++; $display("FAIL rstrb[%0d] miso: got %h want %h", i, o_miso, e_miso);
            end
            checks++;
            if (o_tail !== 2'b00) begin
                errors++; $display("FAIL rstrb[%0d] tail: got %b want 00", i, o_tail);
            end
            if (tv[i].rst_at < tv[i].n) begin
                checks++;
                if (o_rst_rxd !== 10'h000) begin
                    errors++; $display("FAIL rstrb[%0d] rx_data: got %h want 000", i, o_rst_rxd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        for (int i = 0; i < 24; i++) begin
            t = mk(10'($urandom), $urandom_range(8, 24), $urandom_range(9, 16),
                   8'($urandom), 8'($urandom), 1'($urandom), 1000);
            run_frame(t);
            model_frame(t);
            checks++;
            if (o_rx !== e_rx) begin
                errors++; $display("FAIL b2b[%0d] rx: got %h want %h", i, o_rx, e_rx);
            end
            checks++;
            if (o_miso !== e_miso) begin
                errors++; $display("FAIL b2b[%0d] miso: got %h want %h", i, o_miso, e_miso);
            end
            checks++;
            if (o_tail !== 2'b00) begin
                errors++; $display("FAIL b2b[%0d] tail: got %b want 00", i, o_tail);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_readback();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
